// File: rtl/send_shift_pkg.sv
// send_shift_pkg: operation encoding shared by the shift register
package send_shift_pkg;
  typedef enum logic {OP_SHIFT, OP_LOAD} op_e;
endpackage

// File: rtl/send_shift.sv
// send_shift: WIDTH-bit parallel-load, MSB-first serial shift register
module send_shift
  import send_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             cin,
  output logic [0:WIDTH-1] out,
  output logic             sout
);
  op_e op;
  logic [WIDTH-1:0] sh_d, sh_q;
  // next register value: load wins over shift, cin enters at the LSB
  always_comb begin
    op = load ? OP_LOAD : OP_SHIFT;
    sh_d = (op == OP_LOAD) ? in : {sh_q[WIDTH-2:0], cin};
  end
  // register with synchronous reset taking priority over load and shift
  always_ff @(posedge clk)
    if (rst) sh_q <= '0;
    else sh_q <= sh_d;
  assign out = sh_q;
  assign sout = sh_q[WIDTH-1];
endmodule

// File: tb/tb_send_shift.sv
// tb_send_shift: scoreboarded random and directed check of send_shift
module tb_send_shift;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, cin = 1'b0;
  logic [W-1:0] in = '0;
  logic [0:W-1] out;
  logic sout;
  int checks = 0, fails = 0;
  int model = 0;
  int exp_q[$];
  bit done = 1'b0;
  int pat[5] = '{1, 2, 3, 7, 10};

  send_shift #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .load(load), .in(in), .cin(cin), .out(out), .sout(sout));

  always #20 clk = ~clk;

  task automatic step(input bit r, input bit l, input int i, input bit c);
    @(negedge clk);
    rst = r; load = l; in = i[W-1:0]; cin = c;
    if (r) model = 0;
    else if (l) model = i % (1 << W);
    else model = (model * 2 + int'(c)) % (1 << W);
    exp_q.push_back(model);
  endtask

  initial begin : monitor
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(out) != e) begin
          fails++;
          $display("FAIL out: got %b expected %b at %0t", out, e[W-1:0], $time);
        end
        checks++;
        if (sout != ((e >> (W - 1)) % 2 == 1)) begin
          fails++;
          $display("FAIL sout: got %b expected %0d at %0t", sout, (e >> (W - 1)) % 2, $time);
        end
      end
    end
  end

  initial begin : stim
    int k;
    step(1, 1, 10, 0);
    step(0, 1, 1, 0);
    step(0, 1, 10, 0);
    step(0, 1, 1, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 5, 1);
    step(0, 1, 10, 1);
    for (int n = 0; n < 4; n++) step(0, 0, 15, 0);
    step(0, 1, 0, 1);
    step(0, 1, 15, 1);
    step(1, 1, 15, 1);
    step(0, 0, 0, 1);
    k = 0;
    for (int n = 0; n < 20; n++) begin
      step(0, (n / 2) % 2 == 0, pat[k], n % 3 == 0);
      if (n % 4 == 3) k = (k + 1) % 5;
    end
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
